// File: rtl/hash_pkg.sv
// hash_pkg: types and constants shared by the hash
// sequencer, hash assembler and compression engine.
package hash_pkg;

  localparam int HASH_LENGTH  = 8;
  localparam int WORD_WIDTH   = 32;
  localparam int DIGEST_WIDTH = HASH_LENGTH * WORD_WIDTH;

  typedef enum logic [2:0] {
    HS_IDLE,
    HS_LOAD,
    HS_LOAD_DONE,
    HS_COMP_START,
    HS_COMP_WAIT,
    HS_WRITE,
    HS_DONE
  } hash_seq_state_t;

  // Digest word i lives at bits [32*i +: 32].
  function automatic logic [WORD_WIDTH-1:0] digest_word(
    input logic [DIGEST_WIDTH-1:0] d,
    input int unsigned             i
  );
    return d[WORD_WIDTH*i +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/hash_sequencer_if.sv
// hash_sequencer_if: job control, hash SRAM, assembler,
// compression engine and output SRAM signals.
interface hash_sequencer_if #(
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int HW = $clog2(hash_pkg::HASH_LENGTH),
  parameter int DW = hash_pkg::DIGEST_WIDTH
);

  logic                       start;
  logic [7:0]                 num_blocks;
  logic                       busy;
  logic                       done;
  logic                       hsram_rd_en;
  logic [SRAM_ADDR_WIDTH-1:0] hsram_addr;
  logic [31:0]                hsram_rd_data;
  logic                       hash_enable;
  logic [HW-1:0]              hash_address;
  logic [31:0]                hash_data;
  logic                       hash_addr_complete;
  logic                       compress_start;
  logic                       compress_done;
  logic [DW-1:0]              digest;
  logic                       out_wr_en;
  logic [SRAM_ADDR_WIDTH-1:0] out_addr;
  logic [31:0]                out_wr_data;

  modport master (
    input  start, num_blocks, hsram_rd_data,
    input  compress_done, digest,
    output busy, done, hsram_rd_en, hsram_addr,
    output hash_enable, hash_address, hash_data,
    output hash_addr_complete, compress_start,
    output out_wr_en, out_addr, out_wr_data
  );

  modport slave (
    output start, num_blocks, hsram_rd_data,
    output compress_done, digest,
    input  busy, done, hsram_rd_en, hsram_addr,
    input  hash_enable, hash_address, hash_data,
    input  hash_addr_complete, compress_start,
    input  out_wr_en, out_addr, out_wr_data
  );

endinterface

// File: rtl/hash_sequencer.sv
// hash_sequencer: loads H0..H7 into the assembler, runs
// one compression per block, writes the digest out.
module hash_sequencer #(
  parameter int HASH_LENGTH = 8,
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter logic [SRAM_ADDR_WIDTH-1:0] H_BASE_ADDR = '0,
  parameter logic [SRAM_ADDR_WIDTH-1:0] OUT_BASE_ADDR = '0
) (
  input logic              clock,
  input logic              reset,
  hash_sequencer_if.master bus
);

  import hash_pkg::*;

  localparam int HW = $clog2(HASH_LENGTH);
  localparam int DW = HASH_LENGTH * WORD_WIDTH;
  localparam logic [HW-1:0] LAST = HW'(HASH_LENGTH - 1);

  hash_seq_state_t       state;
  hash_seq_state_t       state_nx;
  logic [7:0]            blocks_left;
  logic [HW-1:0]         rd_idx;
  logic [HW-1:0]         wr_idx;
  logic [HW-1:0]         hash_idx;
  logic                  rd_vld;
  logic                  hash_en;
  logic [WORD_WIDTH-1:0] hash_word;
  logic [DW-1:0]         digest_reg;
  logic                  comp_last;

  assign comp_last = (blocks_left <= 8'd1);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= HS_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      HS_IDLE:
        if (bus.start) state_nx = HS_LOAD;
      HS_LOAD:
        if (rd_idx == LAST) state_nx = HS_LOAD_DONE;
      HS_LOAD_DONE:
        if (!rd_vld) state_nx = HS_COMP_START;
      HS_COMP_START:
        state_nx = HS_COMP_WAIT;
      HS_COMP_WAIT:
        if (bus.compress_done)
          state_nx = comp_last ? HS_WRITE : HS_COMP_START;
      HS_WRITE:
        if (wr_idx == LAST) state_nx = HS_DONE;
      HS_DONE:
        state_nx = HS_IDLE;
      default:
        state_nx = HS_IDLE;
    endcase
  end

  // Counters, read-valid pipe, held word, digest capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      blocks_left <= '0;
      rd_idx      <= '0;
      wr_idx      <= '0;
      hash_idx    <= '0;
      rd_vld      <= 1'b0;
      hash_en     <= 1'b0;
      hash_word   <= '0;
      digest_reg  <= '0;
    end else begin
      rd_vld <= (state == HS_LOAD);
      if (rd_vld) hash_word <= bus.hsram_rd_data;
      if (state == HS_IDLE && bus.start) begin
        blocks_left <= (bus.num_blocks == 8'd0) ?
                       8'd1 : bus.num_blocks;
        rd_idx      <= '0;
      end
      if (state == HS_LOAD) begin
        rd_idx   <= rd_idx + 1'b1;
        hash_idx <= rd_idx;
        hash_en  <= 1'b1;
      end
      if (state == HS_COMP_WAIT && bus.compress_done) begin
        if (comp_last) begin
          digest_reg <= bus.digest;
          wr_idx     <= '0;
        end else begin
          blocks_left <= blocks_left - 8'd1;
        end
      end
      if (state == HS_WRITE) wr_idx <= wr_idx + 1'b1;
      if (state == HS_DONE)  hash_en <= 1'b0;
    end
  end

  // Output decode; everything idles at zero.
  always_comb begin
    bus.busy               = (state != HS_IDLE);
    bus.done               = (state == HS_DONE);
    bus.hsram_rd_en        = (state == HS_LOAD);
    bus.hsram_addr         = '0;
    bus.hash_enable        = hash_en;
    bus.hash_address       = '0;
    bus.hash_data          = '0;
    bus.hash_addr_complete = (state == HS_LOAD_DONE) && !rd_vld;
    bus.compress_start     = (state == HS_COMP_START);
    bus.out_wr_en          = (state == HS_WRITE);
    bus.out_addr           = '0;
    bus.out_wr_data        = '0;
    if (state == HS_LOAD)
      bus.hsram_addr = H_BASE_ADDR + SRAM_ADDR_WIDTH'(rd_idx);
    if (hash_en) begin
      bus.hash_address = hash_idx;
      bus.hash_data    = rd_vld ? bus.hsram_rd_data : hash_word;
    end
    if (state == HS_WRITE) begin
      bus.out_addr    = OUT_BASE_ADDR + SRAM_ADDR_WIDTH'(wr_idx);
      bus.out_wr_data = digest_reg[WORD_WIDTH*wr_idx +: WORD_WIDTH];
    end
  end

endmodule

// File: tb/tb_hash_sequencer.sv
// tb_hash_sequencer: scoreboard bench with hash SRAM and
// compression engine models around hash_sequencer.
module tb_hash_sequencer;

  localparam logic [15:0] H_BASE   = 16'h0100;
  localparam logic [15:0] OUT_BASE = 16'hFFFC;

  localparam logic [31:0] HINIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] DIG [8] = '{
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf
  };

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  typedef struct {
    int          c;
    logic [15:0] a;
    logic [31:0] d;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  hash_sequencer_if bus ();

  hash_sequencer #(
    .HASH_LENGTH     (8),
    .SRAM_ADDR_WIDTH (16),
    .H_BASE_ADDR     (H_BASE),
    .OUT_BASE_ADDR   (OUT_BASE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int  cyc = 0;
  int  pend = -1;
  bit  spur = 1'b0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  t0;
  int  t1;

  ev_t rd_obs [$];
  ev_t asm_obs [$];
  ev_t wr_obs [$];
  int  cpl_obs [$];
  int  cs_obs [$];
  int  done_obs [$];
  ev_t exp_rd [$];
  ev_t exp_asm [$];
  ev_t exp_wr [$];

  logic       prev_en = 1'b0;
  logic [2:0] prev_addr = 3'd0;

  logic [105:0] outs;
  assign outs = {
    bus.busy, bus.done, bus.hsram_rd_en, bus.hsram_addr,
    bus.hash_enable, bus.hash_address, bus.hash_data,
    bus.hash_addr_complete, bus.compress_start,
    bus.out_wr_en, bus.out_addr, bus.out_wr_data
  };

  always @(posedge clock) cyc <= cyc + 1;

  // Hash SRAM: one-cycle read latency.
  always @(posedge clock) begin
    if (bus.hsram_rd_en)
      bus.hsram_rd_data <= HINIT[3'(bus.hsram_addr - H_BASE)];
  end

  // Compression engine model and output monitor.
  always @(negedge clock) begin
    if (reset)                   pend <= -1;
    else if (bus.compress_start) pend <= cyc + 5;
    bus.compress_done <= spur || (!reset && cyc == pend);
    if (bus.hsram_rd_en)
      rd_obs.push_back('{cyc, bus.hsram_addr, 32'h0});
    if (bus.hash_enable &&
        (!prev_en || bus.hash_address != prev_addr))
      asm_obs.push_back('{cyc, 16'(bus.hash_address), bus.hash_data});
    prev_en   <= bus.hash_enable;
    prev_addr <= bus.hash_address;
    if (bus.hash_addr_complete) cpl_obs.push_back(cyc);
    if (bus.compress_start)     cs_obs.push_back(cyc);
    if (bus.out_wr_en)
      wr_obs.push_back('{cyc, bus.out_addr, bus.out_wr_data});
    if (bus.done)               done_obs.push_back(cyc);
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_q();
    rd_obs.delete();
    asm_obs.delete();
    wr_obs.delete();
    cpl_obs.delete();
    cs_obs.delete();
    done_obs.delete();
    exp_rd.delete();
    exp_asm.delete();
    exp_wr.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    spur = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    clear_q();
  endtask

  task automatic launch(input logic [7:0] nb, input logic [255:0] dg);
    t0 = cyc;
    bus.num_blocks = nb;
    bus.digest = dg;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (done_obs.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (done_obs.size() >= n);
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    launch(8'd1, DIG_ABC);
    repeat (3) step();
    reset = 1'b1;
    step();
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_load_outputs: got %h, required 0", outs);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_load_busy: got %b, required 0", bus.busy);
    end
    reset = 1'b0;
    repeat (6) step();
    n_checks++;
    if (rd_obs.size() != 4 || cs_obs.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_strobes: reads %0d starts %0d, required 4 and 0",
               rd_obs.size(), cs_obs.size());
    end
    clear_q();
    launch(8'd1, DIG_ABC);
    n_checks++;
    if (bus.hsram_rd_en !== 1'b1 || bus.hsram_addr !== H_BASE) begin
      n_fail++;
      $display("FAIL reset_reread: rd_en %b addr %h, required 1 and %h",
               bus.hsram_rd_en, bus.hsram_addr, H_BASE);
    end
    wait_done(1, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_rerun_done: done count %0d, required 1",
               done_obs.size());
    end
  endtask

  task automatic test_load();
    ev_t e;
    ev_t o;
    bit  ok;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_rd.push_back('{t0 + 0, 16'h0, 32'h0});
    end
    exp_rd.delete();
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      exp_rd.push_back('{t0 + 1 + i, H_BASE + 16'(i), 32'h0});
      exp_asm.push_back('{t0 + 2 + i, 16'(i), HINIT[i]});
    end
    launch(8'd1, DIG_ABC);
    wait_done(1, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL load_done: done count %0d, required 1", done_obs.size());
    end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      if (rd_obs.size() > 0) o = rd_obs.pop_front();
      else o = '{-1, 16'h0, 32'h0};
      n_checks++;
      if (o.c !== e.c || o.a !== e.a) begin
        n_fail++;
        $display("FAIL load_read: cycle %0d addr %h, required cycle %0d addr %h",
                 o.c - t0, o.a, e.c - t0, e.a);
      end
    end
    while (exp_asm.size() > 0) begin
      e = exp_asm.pop_front();
      if (asm_obs.size() > 0) o = asm_obs.pop_front();
      else o = '{-1, 16'h0, 32'h0};
      n_checks++;
      if (o.c !== e.c || o.a !== e.a || o.d !== e.d) begin
        n_fail++;
        $display("FAIL load_assembler: cycle %0d idx %0d data %h, required cycle %0d idx %0d data %h",
                 o.c - t0, o.a, o.d, e.c - t0, e.a, e.d);
      end
    end
    n_checks++;
    if (cpl_obs.size() != 1 || cpl_obs[0] != t0 + 10) begin
      n_fail++;
      $display("FAIL load_complete: count %0d, required one pulse at cycle 10",
               cpl_obs.size());
    end
    n_checks++;
    if (cs_obs.size() != 1 || cs_obs[0] != t0 + 11) begin
      n_fail++;
      $display("FAIL load_compress_start: count %0d, required one pulse at cycle 11",
               cs_obs.size());
    end
  endtask

  task automatic test_multi_block();
    bit ok;
    do_reset();
    launch(8'd3, DIG_ABC);
    wait_done(1, 200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL multi_done: done count %0d, required 1", done_obs.size());
    end
    n_checks++;
    if (cs_obs.size() != 3) begin
      n_fail++;
      $display("FAIL multi_start_count: got %0d, required 3", cs_obs.size());
    end
    for (int k = 0; k < cs_obs.size() && k < 3; k++) begin
      n_checks++;
      if (cs_obs[k] != t0 + 11 + 6 * k) begin
        n_fail++;
        $display("FAIL multi_start_time: pulse %0d at cycle %0d, required %0d",
                 k, cs_obs[k] - t0, 11 + 6 * k);
      end
    end
    n_checks++;
    if (wr_obs.size() != 8 || wr_obs[0].c != t0 + 29 ||
        done_obs.size() == 0 || done_obs[0] != t0 + 37) begin
      n_fail++;
      $display("FAIL multi_write_time: writes %0d, required 8 from cycle 29, done at 37",
               wr_obs.size());
    end
  endtask

  task automatic test_zero_blocks();
    bit ok;
    do_reset();
    launch(8'd0, DIG_ABC);
    wait_done(1, 200, ok);
    n_checks++;
    if (!ok || cs_obs.size() != 1 || cs_obs[0] != t0 + 11) begin
      n_fail++;
      $display("FAIL zero_blocks_start: starts %0d, required 1 at cycle 11",
               cs_obs.size());
    end
    n_checks++;
    if (done_obs.size() != 1 || done_obs[0] != t0 + 25) begin
      n_fail++;
      $display("FAIL zero_blocks_done: done count %0d, required 1 at cycle 25",
               done_obs.size());
    end
  endtask

  task automatic test_digest_write();
    ev_t e;
    ev_t o;
    bit  ok;
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      exp_wr.push_back('{t0 + 17 + i, OUT_BASE + 16'(i), DIG[i]});
    launch(8'd1, DIG_ABC);
    wait_done(1, 100, ok);
    n_checks++;
    if (wr_obs.size() != 8) begin
      n_fail++;
      $display("FAIL digest_write_count: got %0d, required 8", wr_obs.size());
    end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      if (wr_obs.size() > 0) o = wr_obs.pop_front();
      else o = '{-1, 16'h0, 32'h0};
      n_checks++;
      if (o.c !== e.c || o.a !== e.a || o.d !== e.d) begin
        n_fail++;
        $display("FAIL digest_write: cycle %0d addr %h data %h, required cycle %0d addr %h data %h",
                 o.c - t0, o.a, o.d, e.c - t0, e.a, e.d);
      end
    end
    n_checks++;
    if (!ok || done_obs[0] != t0 + 25) begin
      n_fail++;
      $display("FAIL digest_done: done count %0d, required one pulse at cycle 25",
               done_obs.size());
    end
  endtask

  task automatic test_spurious();
    bit ok;
    do_reset();
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (2) step();
    n_checks++;
    if (bus.busy !== 1'b0 || cs_obs.size() != 0 || wr_obs.size() != 0) begin
      n_fail++;
      $display("FAIL spurious_idle: busy %b starts %0d writes %0d, required 0 0 0",
               bus.busy, cs_obs.size(), wr_obs.size());
    end
    launch(8'd1, DIG_ABC);
    repeat (3) step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (8) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(1, 100, ok);
    repeat (3) step();
    n_checks++;
    if (!ok || done_obs.size() != 1 || done_obs[0] != t0 + 25) begin
      n_fail++;
      $display("FAIL spurious_done: done count %0d, required 1 at cycle 25",
               done_obs.size());
    end
    n_checks++;
    if (cs_obs.size() != 1 || rd_obs.size() != 8 || wr_obs.size() != 8) begin
      n_fail++;
      $display("FAIL spurious_job: starts %0d reads %0d writes %0d, required 1 8 8",
               cs_obs.size(), rd_obs.size(), wr_obs.size());
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_restart: busy %b, required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    launch(8'd1, DIG_ABC);
    wait_done(1, 100, ok);
    n_checks++;
    if (!ok || done_obs[0] != t0 + 25) begin
      n_fail++;
      $display("FAIL b2b_first_done: done count %0d, required 1 at cycle 25",
               done_obs.size());
    end
    bus.start = 1'b1;
    step();
    t1 = cyc;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hash_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: busy %b hash_enable %b, required 0 0",
               bus.busy, bus.hash_enable);
    end
    step();
    bus.start = 1'b0;
    n_checks++;
    if (bus.hsram_rd_en !== 1'b1 || bus.hsram_addr !== H_BASE ||
        bus.hash_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_load: rd_en %b addr %h en %b, required 1 %h 0",
               bus.hsram_rd_en, bus.hsram_addr, bus.hash_enable, H_BASE);
    end
    wait_done(2, 100, ok);
    n_checks++;
    if (!ok || done_obs[1] != t1 + 25 || rd_obs.size() != 16) begin
      n_fail++;
      $display("FAIL b2b_second_done: done count %0d reads %0d, required 2 and 16",
               done_obs.size(), rd_obs.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.num_blocks = 8'd0;
    bus.digest = '0;
    test_reset();
    test_load();
    test_multi_block();
    test_zero_blocks();
    test_digest_write();
    test_spurious();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
